icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Read-only N-way set-associative instruction cache between the fetch stage and the line-wide instruction memory port.
- Generalises the existing 2-way cache:
  - parametrised ways, sets and line size
  - explicit valid bits
  - victim selection that fills invalid ways first, then round-robin per set
  - ready/valid request handshake
  - whole-cache flush
- Hits return in 1 cycle at full throughput; misses refill one line, then return the requested word.

Parameters:
NrWays, 2, associativity; power of two, 1..8
IndexBits, 6, set index width; NrSets = 2**IndexBits
ByteOffsetBits, 4, byte offset width; NrWordsPerLine = 2**ByteOffsetBits/4, must be >= 1
TagBits, 32-IndexBits-ByteOffsetBits, derived; not overridable
LineSize, 32*NrWordsPerLine, derived line width in bits

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
addr_i  in  32  request byte address; bits [1:0] ignored
read_en_i  in  1  request valid
ready_o  out  1  cache can accept a request this cycle
read_valid_o  out  1  read_word_o valid; 1-cycle pulse per accepted request
read_word_o  out  32  returned instruction word
flush_i  in  1  invalidate all lines (1-cycle pulse)
mem_addr_o  out  32  line-aligned refill address
mem_read_en_o  out  1  refill request; held until mem_read_valid_i
mem_read_valid_i  in  1  refill data valid
mem_read_data_i  in  LineSize  refill line; word k at bits [32k+31:32k]

Behaviour:
- Reset: clk_i / rstn_i as already decided (asynchronous, active-low, clock clk_i).
  - During reset: state IDLE; all valid bits 0; all rr pointers 0; flush_pending 0.
  - Output reset values: ready_o 0, read_valid_o 0, read_word_o 0, mem_addr_o 0, mem_read_en_o 0.
- Address split: tag = addr[31:IndexBits+ByteOffsetBits]; index = next IndexBits; word select = addr[ByteOffsetBits-1:2].
- States: IDLE, MISS.
- ready_o = (state==IDLE) && !flush_i && !flush_pending.
- Accept: read_en_i && ready_o at a clock edge.
- IDLE, request accepted:
  - Tags of all ways in set[index] are compared combinationally against addr_i; way hit = valid && tag match.
  - Hit: next cycle read_valid_o=1 and read_word_o = selected word of the hit way; stay IDLE. Back-to-back hits give one word per cycle.
  - Miss: capture the address into req_q; next cycle state=MISS, mem_read_en_o=1, mem_addr_o = {tag, index, 0}; read_valid_o=0.
- MISS:
  - addr_i and read_en_i are ignored; mem_read_en_o and mem_addr_o are held stable.
  - On mem_read_valid_i, write the line into the victim way, set its valid bit and tag, then go to IDLE.
  - Next cycle: read_valid_o=1, read_word_o = selected word of mem_read_data_i, mem_read_en_o=0.
- mem_read_valid_i outside MISS is ignored.
- Victim selection:
  - Lowest-numbered invalid way in the set.
  - If all ways are valid, use rr[set], then increment rr[set] modulo NrWays.
  - rr does not change on hits or on refills into invalid ways.
- Multiple simultaneous tag hits cannot occur. If they do, the lowest way wins and a simulation assertion fires.
- read_word_o holds its last value when read_valid_o=0. The bench checks it only when read_valid_o=1.
- Flush in IDLE:
  - All valid bits and rr pointers are cleared at the edge.
  - A simultaneous read_en_i is not accepted (ready_o=0).
- Flush in MISS:
  - Sets flush_pending; the refill completes normally and returns its word.
  - The clear is applied in the first IDLE cycle after the refill; ready_o=0 during that cycle.
- Reset mid-MISS: the refill is abandoned; mem_read_en_o drops asynchronously; all lines are invalid afterwards.
- NrWays=1 degenerates to direct-mapped; rr logic is tied off.

Decomposition:
- Package icache_pkg holds:
  - state enum (IDLE, MISS)
  - address-split width constants and a split function
  - victim-select function (first-invalid / round-robin)
- Sub-module icache_way: one way's valid/tag/data arrays with a hit compare. Ports: index, tag, write enable, write line; outputs hit and line. Instantiated NrWays times in a generate loop.
- Top level holds the FSM, rr array, flush logic and output mux.

Test Plan (NrWays=2, IndexBits=6, ByteOffsetBits=4):
- Cold miss:
  - Stimulus: read 0x0000_0104.
  - Response: next cycle mem_read_en_o=1, mem_addr_o=0x0000_0100.
  - Stimulus: return a line with word1=0xAAAA_0001.
  - Response: read_valid_o=1, read_word_o=0xAAAA_0001 one cycle after mem_read_valid_i.
- Hit streaming:
  - Stimulus: after the cold miss, reads 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - Response: four consecutive read_valid_o pulses with the matching words; mem_read_en_o stays 0.
- Replacement in set 0x10:
  - Stimulus: miss on 0x100 (tag 0), then 0x500 (tag 1), then 0x900 (tag 2).
  - Response: tag 2 evicts way 0.
  - Check: read 0x500 hits; read 0x100 misses and evicts way 1 (rr=1).
- Flush in IDLE:
  - Stimulus: flush_i together with read_en_i.
  - Response: ready_o=0, no read_valid_o; the next read of 0x104 misses.
- Flush during MISS:
  - Stimulus: flush_i mid-refill of 0x100.
  - Response: word returned; ready_o=0 for 1 cycle; a re-read of 0x100 misses.
- Reset during MISS:
  - Stimulus: rstn_i=0 while mem_read_en_o=1.
  - Response: mem_read_en_o=0 immediately; after release, a read of a previously cached line misses.

Source files
------------

// File: rtl/icache_nway_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and helpers for the N-way instruction cache.
//   state_e      : controller state (IDLE / MISS)
//   addr_split_t : byte address split into tag / set index / word select
//   split_addr() : performs the split for a given index/offset geometry
//   victim_t     : replacement decision (way, and whether the rr pointer chose it)
//   pick_victim(): lowest invalid way first, otherwise the round-robin pointer
// No ports (package).
// -----------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  // Instruction words are 32-bit, so the two lowest byte-address bits never
  // take part in the lookup.
  localparam int WordOffsetBits = 2;

  // Widest associativity supported; the victim helper works on this width.
  localparam int MaxWays = 8;

  // Fields are 32 bits wide so one struct serves every geometry; callers
  // truncate to their real widths.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] word;
  } addr_split_t;

  typedef struct packed {
    logic [2:0] way;
    logic       use_rr;
  } victim_t;

  function automatic addr_split_t split_addr(input logic [31:0] addr,
                                             input int          index_bits,
                                             input int          offset_bits);
    addr_split_t s;
    logic [31:0] idx_mask;
    logic [31:0] word_mask;
    idx_mask  = (32'd1 << index_bits) - 32'd1;
    word_mask = (32'd1 << (offset_bits - WordOffsetBits)) - 32'd1;
    s.tag     = addr >> (index_bits + offset_bits);
    s.index   = (addr >> offset_bits) & idx_mask;
    s.word    = (addr >> WordOffsetBits) & word_mask;
    return s;
  endfunction

  // Scanning from the top down leaves the lowest-numbered invalid way as the
  // final choice.  Ways at or above nr_ways are never considered.
  function automatic victim_t pick_victim(input logic [MaxWays-1:0] valid,
                                          input logic [2:0]         rr,
                                          input int                 nr_ways);
    victim_t v;
    v.way    = rr;
    v.use_rr = 1'b1;
    for (int w = MaxWays - 1; w >= 0; w--) begin
      if (w < nr_ways && !valid[w]) begin
        v.way    = 3'(w);
        v.use_rr = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/icache_nway_if.sv
// -----------------------------------------------------------------------------
// icache_nway_if
// Bundles the fetch-side request/response and the line refill port.
//   fetch : addr, read_en, flush (to cache); ready, read_valid, read_word (from)
//   memory: mem_addr, mem_read_en (from cache); mem_read_valid, mem_read_data (to)
// Modports:
//   slave  - the cache itself
//   master - fetch stage plus instruction memory (the environment)
// -----------------------------------------------------------------------------
interface icache_nway_if #(
  parameter int LineSize = 128
) ();

  logic [31:0]         addr;
  logic                read_en;
  logic                ready;
  logic                read_valid;
  logic [31:0]         read_word;
  logic                flush;
  logic [31:0]         mem_addr;
  logic                mem_read_en;
  logic                mem_read_valid;
  logic [LineSize-1:0] mem_read_data;

  modport slave (
    input  addr, read_en, flush, mem_read_valid, mem_read_data,
    output ready, read_valid, read_word, mem_addr, mem_read_en
  );

  modport master (
    output addr, read_en, flush, mem_read_valid, mem_read_data,
    input  ready, read_valid, read_word, mem_addr, mem_read_en
  );

endinterface

// File: rtl/icache_nway_way.sv
// -----------------------------------------------------------------------------
// icache_way
// One way of the cache: valid bits, tag store and line store for every set.
//   clk_i, rstn_i : clock, asynchronous active-low reset (clears valid bits)
//   clear_i       : invalidate every set of this way
//   index_i       : set being looked up or written
//   tag_i         : tag to compare / tag to store on write
//   rd_en_i       : latch the line of set index_i into line_o (next cycle)
//   we_i          : write wr_line_i and tag_i into set index_i, mark it valid
//   wr_line_i     : refill line
//   valid_o       : valid bit of set index_i (combinational)
//   hit_o         : valid and tag match for set index_i (combinational)
//   line_o        : registered line read
// -----------------------------------------------------------------------------
module icache_way
  import icache_pkg::*;
#(
  parameter int IndexBits = 6,
  parameter int TagBits   = 22,
  parameter int LineSize  = 128
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic [IndexBits-1:0] index_i,
  input  logic [TagBits-1:0]   tag_i,
  input  logic                 rd_en_i,
  input  logic                 we_i,
  input  logic [LineSize-1:0]  wr_line_i,
  output logic                 valid_o,
  output logic                 hit_o,
  output logic [LineSize-1:0]  line_o
);

  localparam int NrSets = 2**IndexBits;

  logic [NrSets-1:0]   valid_q;
  logic [TagBits-1:0]  tag_mem  [NrSets];
  logic [LineSize-1:0] data_mem [NrSets];
  logic [LineSize-1:0] line_q;

  // Valid bits live in flops so reset and flush clear every set at once.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Tags are read combinationally for the same-cycle hit decision; the line
  // store uses a registered read so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[index_i]  <= tag_i;
      data_mem[index_i] <= wr_line_i;
    end
    if (rd_en_i) begin
      line_q <= data_mem[index_i];
    end
  end

  assign valid_o = valid_q[index_i];
  assign hit_o   = valid_o && (tag_mem[index_i] == tag_i);
  assign line_o  = line_q;

endmodule

// File: rtl/icache_nway.sv
// -----------------------------------------------------------------------------
// icache_nway
// Read-only N-way set-associative instruction cache.  Hits answer one cycle
// after acceptance at full rate; a miss fetches one line from memory, writes it
// into a victim way and then answers with the requested word.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset
//   bus    : icache_nway_if.slave (fetch request/response + line refill port)
// Parameters: NrWays (power of two, 1..8), IndexBits, ByteOffsetBits (>= 2).
// -----------------------------------------------------------------------------
module icache_nway
  import icache_pkg::*;
#(
  parameter int NrWays         = 2,
  parameter int IndexBits      = 6,
  parameter int ByteOffsetBits = 4
) (
  input logic          clk_i,
  input logic          rstn_i,
  icache_nway_if.slave bus
);

  localparam int TagBits        = 32 - IndexBits - ByteOffsetBits;
  localparam int NrSets         = 2**IndexBits;
  localparam int NrWordsPerLine = (2**ByteOffsetBits) / 4;
  localparam int LineSize       = 32 * NrWordsPerLine;
  localparam int WayBits        = (NrWays > 1) ? $clog2(NrWays) : 1;
  localparam int WselBits       = (ByteOffsetBits > 2) ? ByteOffsetBits - 2 : 1;

  state_e state_q, state_d;

  logic [31:0]          req_q;
  logic [31:0]          lookup_addr;
  addr_split_t          lk;
  logic [IndexBits-1:0] lk_index;
  logic [TagBits-1:0]   lk_tag;
  logic [WselBits-1:0]  lk_word;

  logic ready;
  logic accept;
  logic flush_now;
  logic refill_done;

  logic [NrWays-1:0]   way_hit;
  logic [NrWays-1:0]   way_valid;
  logic [NrWays-1:0]   way_we;
  logic [LineSize-1:0] way_line [NrWays];

  logic                hit_any;
  logic [WayBits-1:0]  hit_way;
  logic [WayBits-1:0]  rr_cur;
  logic [WayBits-1:0]  victim_way;
  logic [MaxWays-1:0]  valid_ext;
  victim_t             victim;

  logic                read_valid_q;
  logic                from_ram_q;
  logic [WayBits-1:0]  hit_way_q;
  logic [WselBits-1:0] wsel_q;
  logic [31:0]         read_word_q;
  logic                mem_read_en_q;
  logic [31:0]         mem_addr_q;
  logic                flush_pending_q;

  logic [LineSize-1:0] hit_line;
  logic [31:0]         ram_word;
  logic [31:0]         refill_word;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !hit_any) state_d = MISS;
      MISS:    if (bus.mem_read_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While a refill is outstanding the lookup port follows the captured
  // request, so the victim's set, tag and word select all come from req_q.
  always_comb begin
    ready       = 1'b0;
    flush_now   = 1'b0;
    refill_done = 1'b0;
    lookup_addr = bus.addr;
    case (state_q)
      IDLE: begin
        ready     = rstn_i && !bus.flush && !flush_pending_q;
        flush_now = bus.flush || flush_pending_q;
      end
      MISS: begin
        lookup_addr = req_q;
        refill_done = bus.mem_read_valid;
      end
      default: ;
    endcase
  end

  assign accept = bus.read_en && ready;

  // ---------------------------------------------------------------- lookup
  assign lk       = split_addr(lookup_addr, IndexBits, ByteOffsetBits);
  assign lk_index = IndexBits'(lk.index);
  assign lk_tag   = TagBits'(lk.tag);
  assign lk_word  = WselBits'(lk.word);

  for (genvar gi = 0; gi < NrWays; gi++) begin : g_way
    assign way_we[gi] = refill_done && (victim_way == WayBits'(gi));

    icache_way #(
      .IndexBits (IndexBits),
      .TagBits   (TagBits),
      .LineSize  (LineSize)
    ) u_way (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .clear_i   (flush_now),
      .index_i   (lk_index),
      .tag_i     (lk_tag),
      .rd_en_i   (accept),
      .we_i      (way_we[gi]),
      .wr_line_i (bus.mem_read_data),
      .valid_o   (way_valid[gi]),
      .hit_o     (way_hit[gi]),
      .line_o    (way_line[gi])
    );
  end

  // Lowest hitting way wins should more than one ever match.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = NrWays - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WayBits'(w);
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rstn_i) accept |-> $onehot0(way_hit));

  // ---------------------------------------------------------------- replacement
  always_comb begin
    valid_ext = '0;
    for (int w = 0; w < NrWays; w++) begin
      valid_ext[w] = way_valid[w];
    end
  end

  assign victim     = pick_victim(valid_ext, 3'(rr_cur), NrWays);
  assign victim_way = WayBits'(victim.way);

  if (NrWays > 1) begin : g_rr
    logic [WayBits-1:0] rr_q [NrSets];

    // The pointer only moves when it actually chose the victim.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        for (int s = 0; s < NrSets; s++) rr_q[s] <= '0;
      end else if (flush_now) begin
        for (int s = 0; s < NrSets; s++) rr_q[s] <= '0;
      end else if (refill_done && victim.use_rr) begin
        rr_q[lk_index] <= rr_q[lk_index] + WayBits'(1);
      end
    end

    assign rr_cur = rr_q[lk_index];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  // ---------------------------------------------------------------- datapath
  assign hit_line    = way_line[hit_way_q];
  assign ram_word    = hit_line[32*int'(wsel_q) +: 32];
  assign refill_word = bus.mem_read_data[32*int'(lk_word) +: 32];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      read_valid_q    <= 1'b0;
      from_ram_q      <= 1'b0;
      hit_way_q       <= '0;
      wsel_q          <= '0;
      read_word_q     <= '0;
      req_q           <= '0;
      mem_read_en_q   <= 1'b0;
      mem_addr_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      read_valid_q <= (accept && hit_any) || refill_done;
      from_ram_q   <= accept && hit_any;

      if (accept && hit_any) begin
        hit_way_q <= hit_way;
        wsel_q    <= lk_word;
      end

      // The word shown after a hit comes straight from the line RAM output;
      // it is copied here one cycle later so the output holds afterwards.
      if (refill_done) begin
        read_word_q <= refill_word;
      end else if (from_ram_q) begin
        read_word_q <= ram_word;
      end

      if (accept && !hit_any) begin
        req_q         <= bus.addr;
        mem_read_en_q <= 1'b1;
        mem_addr_q    <= {bus.addr[31:ByteOffsetBits], ByteOffsetBits'(0)};
      end else if (refill_done) begin
        mem_read_en_q <= 1'b0;
      end

      // A flush seen during a refill is remembered and applied in the first
      // IDLE cycle, where flush_now clears the arrays.
      if (state_q == MISS) begin
        if (bus.flush) flush_pending_q <= 1'b1;
      end else begin
        flush_pending_q <= 1'b0;
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.read_valid  = read_valid_q;
  assign bus.read_word   = from_ram_q ? ram_word : read_word_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_read_en = mem_read_en_q;

endmodule

// File: tb/tb_icache_nway.sv
// -----------------------------------------------------------------------------
// tb_icache_nway
// Drives the cache as fetch stage and instruction memory.  Memory contents are
// a fixed function of the address; a set/way occupancy model with the
// first-invalid / round-robin rule predicts hits and misses.
// -----------------------------------------------------------------------------
module tb_icache_nway;

  localparam int NW = 2;
  localparam int IB = 6;
  localparam int OB = 4;
  localparam int NS = 64;
  localparam int LS = 128;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  icache_nway_if #(.LineSize(LS)) bus ();

  icache_nway #(
    .NrWays         (NW),
    .IndexBits      (IB),
    .ByteOffsetBits (OB)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Occupancy model: which tags each set holds and its replacement pointer.
  bit m_valid [NS][NW];
  int m_tag   [NS][NW];
  int m_rr    [NS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hAAAA_0105;
  endfunction

  function automatic logic [LS-1:0] line_data(input logic [31:0] la);
    logic [LS-1:0] d;
    for (int k = 0; k < LS / 32; k++) d[32*k +: 32] = mem_word(la + 32'(4 * k));
    return d;
  endfunction

  function automatic bit model_is_hit(input logic [31:0] a);
    int s = int'((a >> 4) & 32'h3F);
    int t = int'(a >> 10);
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s = int'((a >> 4) & 32'h3F);
    int t = int'(a >> 10);
    int v = -1;
    for (int w = 0; w < NW; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v       = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NW;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    model_clear();
  endtask

  // One complete read (with refill if needed).  Reports what was observed;
  // proto_ok drops on any handshake irregularity or expired wait.
  task automatic do_read(input  logic [31:0] a,
                         output bit          hit,
                         output logic [31:0] word,
                         output logic [31:0] maddr,
                         output bit          proto_ok);
    int n;
    int lat;
    proto_ok = 1'b1;
    hit      = 1'b0;
    word     = '0;
    maddr    = '0;
    n = 0;
    while (!bus.ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ready) proto_ok = 1'b0;
    bus.addr    = a;
    bus.read_en = 1'b1;
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    bus.addr    = $urandom;
    if (bus.read_valid) begin
      hit  = 1'b1;
      word = bus.read_word;
      if (bus.mem_read_en) proto_ok = 1'b0;
    end else if (bus.mem_read_en) begin
      maddr = bus.mem_addr;
      lat   = $urandom_range(0, 3);
      repeat (lat) begin
        // Requests during a refill must be ignored.
        bus.read_en = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (!bus.mem_read_en || bus.mem_addr !== maddr || bus.read_valid || bus.ready)
          proto_ok = 1'b0;
      end
      bus.mem_read_valid = 1'b1;
      bus.mem_read_data  = line_data(maddr);
      @(posedge clk); #1;
      bus.read_en        = 1'b0;
      bus.mem_read_valid = 1'b0;
      bus.mem_read_data  = {$urandom, $urandom, $urandom, $urandom};
      if (!bus.read_valid || bus.mem_read_en) proto_ok = 1'b0;
      word = bus.read_word;
    end else begin
      proto_ok = 1'b0;
    end
    $display("rd addr=%h hit=%0d word=%h memaddr=%h ok=%0d", a, hit, word, maddr, proto_ok);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    vectors++;
    if (bus.read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_read_valid got=%b exp=0", bus.read_valid); end
    vectors++;
    if (bus.read_word !== 32'h0) begin miscompares++; $display("FAIL reset_read_word got=%h exp=0", bus.read_word); end
    vectors++;
    if (bus.mem_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read_en got=%b exp=0", bus.mem_read_en); end
    vectors++;
    if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    rstn = 1'b1;
    model_clear();
    @(posedge clk); #1;
    vectors++;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got=%b exp=1", bus.ready); end
    $display("reset done");
  endtask

  task automatic test_cold_miss();
    bit hit, ok;
    logic [31:0] word, maddr;
    do_read(32'h0000_0104, hit, word, maddr, ok);
    vectors++;
    if (hit !== 1'b0) begin miscompares++; $display("FAIL cold_hit got=%0d exp=0", hit); end
    vectors++;
    if (maddr !== 32'h0000_0100) begin miscompares++; $display("FAIL cold_mem_addr got=%h exp=00000100", maddr); end
    vectors++;
    if (word !== 32'hAAAA_0001) begin miscompares++; $display("FAIL cold_word got=%h exp=aaaa0001", word); end
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL cold_protocol got=%0d exp=1", ok); end
    model_fill(32'h0000_0104);
  endtask

  task automatic test_hit_stream();
    logic [31:0] a;
    bus.addr    = 32'h100;
    bus.read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4 * i);
      @(posedge clk); #1;
      if (i < 3) bus.addr = a + 32'd4;
      else       bus.read_en = 1'b0;
      $display("stream addr=%h valid=%b word=%h", a, bus.read_valid, bus.read_word);
      vectors++;
      if (bus.read_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid addr=%h got=%b exp=1", a, bus.read_valid); end
      vectors++;
      if (bus.read_word !== mem_word(a)) begin miscompares++; $display("FAIL stream_word addr=%h got=%h exp=%h", a, bus.read_word, mem_word(a)); end
      vectors++;
      if (bus.mem_read_en !== 1'b0) begin miscompares++; $display("FAIL stream_mem_read_en addr=%h got=%b exp=0", a, bus.mem_read_en); end
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.read_valid !== 1'b0) begin miscompares++; $display("FAIL stream_valid_end got=%b exp=0", bus.read_valid); end
  endtask

  task automatic test_flush_idle();
    bit hit, ok;
    logic [31:0] word, maddr;
    bus.flush   = 1'b1;
    bus.read_en = 1'b1;
    bus.addr    = 32'h104;
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL flush_idle_ready got=%b exp=0", bus.ready); end
    @(posedge clk); #1;
    bus.flush   = 1'b0;
    bus.read_en = 1'b0;
    model_clear();
    $display("flush idle valid=%b mem_en=%b", bus.read_valid, bus.mem_read_en);
    vectors++;
    if (bus.read_valid !== 1'b0) begin miscompares++; $display("FAIL flush_idle_valid got=%b exp=0", bus.read_valid); end
    vectors++;
    if (bus.mem_read_en !== 1'b0) begin miscompares++; $display("FAIL flush_idle_mem_en got=%b exp=0", bus.mem_read_en); end
    do_read(32'h104, hit, word, maddr, ok);
    vectors++;
    if (hit !== 1'b0) begin miscompares++; $display("FAIL flush_idle_reread_hit got=%0d exp=0", hit); end
    vectors++;
    if (word !== mem_word(32'h104) || ok !== 1'b1) begin
      miscompares++; $display("FAIL flush_idle_reread_word got=%h exp=%h ok=%0d", word, mem_word(32'h104), ok);
    end
    model_fill(32'h104);
  endtask

  task automatic test_replacement();
    logic [31:0] seq_addr [7] = '{32'h100, 32'h500, 32'h900, 32'h500, 32'h100, 32'h900, 32'h500};
    bit          seq_hit  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit hit, ok;
    logic [31:0] word, maddr;
    pulse_flush();
    for (int i = 0; i < 7; i++) begin
      do_read(seq_addr[i], hit, word, maddr, ok);
      vectors++;
      if (hit !== seq_hit[i]) begin miscompares++; $display("FAIL repl_hit step=%0d addr=%h got=%0d exp=%0d", i, seq_addr[i], hit, seq_hit[i]); end
      vectors++;
      if (word !== mem_word(seq_addr[i]) || ok !== 1'b1) begin
        miscompares++; $display("FAIL repl_word step=%0d got=%h exp=%h ok=%0d", i, word, mem_word(seq_addr[i]), ok);
      end
      if (!seq_hit[i]) model_fill(seq_addr[i]);
    end
  endtask

  task automatic test_flush_miss();
    bit hit, ok;
    logic [31:0] word, maddr;
    pulse_flush();
    bus.addr    = 32'h100;
    bus.read_en = 1'b1;
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    vectors++;
    if (bus.mem_read_en !== 1'b1) begin miscompares++; $display("FAIL flush_miss_req got=%b exp=1", bus.mem_read_en); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush          = 1'b0;
    bus.mem_read_valid = 1'b1;
    bus.mem_read_data  = line_data(32'h100);
    @(posedge clk); #1;
    bus.mem_read_valid = 1'b0;
    $display("flush miss valid=%b word=%h ready=%b", bus.read_valid, bus.read_word, bus.ready);
    vectors++;
    if (bus.read_valid !== 1'b1 || bus.read_word !== mem_word(32'h100)) begin
      miscompares++; $display("FAIL flush_miss_word valid=%b got=%h exp=%h", bus.read_valid, bus.read_word, mem_word(32'h100));
    end
    vectors++;
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL flush_miss_ready_low got=%b exp=0", bus.ready); end
    @(posedge clk); #1;
    vectors++;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL flush_miss_ready_back got=%b exp=1", bus.ready); end
    model_clear();
    do_read(32'h100, hit, word, maddr, ok);
    vectors++;
    if (hit !== 1'b0 || ok !== 1'b1) begin miscompares++; $display("FAIL flush_miss_reread_hit got=%0d exp=0 ok=%0d", hit, ok); end
    model_fill(32'h100);
  endtask

  task automatic test_reset_miss();
    bit hit, ok;
    logic [31:0] word, maddr;
    do_read(32'h200, hit, word, maddr, ok);
    model_fill(32'h200);
    do_read(32'h200, hit, word, maddr, ok);
    vectors++;
    if (hit !== 1'b1 || word !== mem_word(32'h200)) begin
      miscompares++; $display("FAIL rstmiss_prehit hit=%0d got=%h exp=%h", hit, word, mem_word(32'h200));
    end
    bus.addr    = 32'h300;
    bus.read_en = 1'b1;
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    vectors++;
    if (bus.mem_read_en !== 1'b1) begin miscompares++; $display("FAIL rstmiss_req got=%b exp=1", bus.mem_read_en); end
    rstn = 1'b0;
    #1;
    $display("reset mid-miss mem_en=%b", bus.mem_read_en);
    vectors++;
    if (bus.mem_read_en !== 1'b0) begin miscompares++; $display("FAIL rstmiss_async_drop got=%b exp=0", bus.mem_read_en); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_clear();
    @(posedge clk); #1;
    do_read(32'h200, hit, word, maddr, ok);
    vectors++;
    if (hit !== 1'b0 || word !== mem_word(32'h200) || ok !== 1'b1) begin
      miscompares++; $display("FAIL rstmiss_after hit=%0d got=%h exp=%h ok=%0d", hit, word, mem_word(32'h200), ok);
    end
    model_fill(32'h200);
  endtask

  task automatic test_random();
    logic [5:0]  sets [4] = '{6'h00, 6'h01, 6'h10, 6'h3F};
    logic [31:0] a;
    logic [31:0] la;
    bit exp_hit, hit, ok;
    logic [31:0] word, maddr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        pulse_flush();
        $display("rand flush");
      end else begin
        a  = (32'($urandom_range(0, 3)) << 10) | (32'(sets[$urandom_range(0, 3)]) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        la = a & 32'hFFFF_FFF0;
        exp_hit = model_is_hit(a);
        do_read(a, hit, word, maddr, ok);
        vectors++;
        if (hit !== exp_hit) begin miscompares++; $display("FAIL rand_hit i=%0d addr=%h got=%0d exp=%0d", i, a, hit, exp_hit); end
        vectors++;
        if (word !== mem_word(a)) begin miscompares++; $display("FAIL rand_word i=%0d addr=%h got=%h exp=%h", i, a, word, mem_word(a)); end
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL rand_protocol i=%0d addr=%h got=%0d exp=1", i, a, ok); end
        if (!hit && ok) begin
          vectors++;
          if (maddr !== la) begin miscompares++; $display("FAIL rand_mem_addr i=%0d got=%h exp=%h", i, maddr, la); end
        end
        if (!exp_hit) model_fill(a);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr           = '0;
    bus.read_en        = 1'b0;
    bus.flush          = 1'b0;
    bus.mem_read_valid = 1'b0;
    bus.mem_read_data  = '0;
    #2;
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_flush_idle();
    test_replacement();
    test_flush_miss();
    test_reset_miss();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
